// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: button indices and repeat FSM encoding.
// Optional feature macro used by this block: BTN_AUTO_REPEAT_EN.
package btn_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;
  localparam int N_BTN = 5;

  typedef enum logic [2:0] {
    REP_IDLE   = 3'b001,
    REP_DELAY  = 3'b010,
    REP_REPEAT = 3'b100
  } rep_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter, press edge and optional auto-repeat.
// Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 80000000,
  parameter int REPEAT_PERIOD   = 16000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic event_o
);
  import btn_pkg::*;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The repeat timer is shared by both waits, so the period must fit in the delay width.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 ||
      REPEAT_PERIOD > REPEAT_DELAY) begin : g_cfg_check
    $error("btn_channel: unsupported timing parameters");
  end

  logic [1:0]       sync_q;
  logic             sync;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  assign sync = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync;
      cnt_d    = '0;
      press_d  = sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int TMR_W = $clog2(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  rep_state_e       state_q;
  logic [TMR_W-1:0] timer_q;
  logic             rep_q;

  // Uses the next stable level so a release never coincides with one last repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REP_IDLE;
      timer_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (press_d) begin
        state_q <= REP_DELAY;
        timer_q <= '0;
      end else if (!stable_d) begin
        state_q <= REP_IDLE;
        timer_q <= '0;
      end else begin
        case (state_q)
          REP_DELAY: begin
            if (timer_q == DELAY_LAST) begin
              state_q <= REP_REPEAT;
              timer_q <= '0;
              rep_q   <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          REP_REPEAT: begin
            if (timer_q == PERIOD_LAST) begin
              timer_q <= '0;
              rep_q   <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: begin
            state_q <= REP_IDLE;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  assign event_o = press_q | rep_q;
`else
  assign event_o = press_q;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: per-button channels, pending event register and priority arbiter.
// Define BTN_AUTO_REPEAT_EN to enable held-button auto-repeat in every channel.
module btn_conditioner #(
  parameter int N_BTN           = btn_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 80000000,
  parameter int REPEAT_PERIOD   = 16000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             cmd_ready,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] pending
);
  import btn_pkg::*;

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] events;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (btn_raw[i]),
      .stable_o(stable[i]),
      .event_o (events[i])
    );
  end

  // Lowest set bit wins; a new event on the bit being issued survives the clear.
  always_comb begin
    pulse_d = '0;
    if (cmd_ready) begin
      pulse_d = pend_q & (~pend_q + 1'b1);
    end
    pend_d = (pend_q & ~pulse_d) | events;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      pulse_q <= '0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_level = stable;
  assign pending   = pend_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/repeat timing.
// The auto-repeat sequence is exercised only when BTN_AUTO_REPEAT_EN is defined.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] btn_raw = '0;
  logic             cmd_ready = 1'b0;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] pending;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .cmd_ready(cmd_ready),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .pending  (pending)
  );

  typedef struct {
    int               cyc;
    logic [N_BTN-1:0] pulse;
  } exp_t;

  typedef struct {
    logic [N_BTN-1:0] raw;
    logic             ready;
    int               hold;
    logic [N_BTN-1:0] strobes;
    int               firstAt;
    logic [N_BTN-1:0] expLevel;
    logic [N_BTN-1:0] expPending;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   compareCount = 0;
  int   failCount = 0;

  task automatic checkOutput(input string name, input logic [N_BTN-1:0] actual,
                             input logic [N_BTN-1:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectPulse(input int at, input logic [N_BTN-1:0] p);
    exp_t e;
    e.cyc   = at;
    e.pulse = p;
    sbq.push_back(e);
  endtask

  // Advance one clock, then compare the strobe against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL missed_pulse: got none, expected %b at cycle %0d", sbq[0].pulse, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      checkOutput("pulse", btn_pulse, sbq[0].pulse);
      void'(sbq.pop_front());
    end else begin
      checkOutput("pulse_idle", btn_pulse, '0);
    end
  endtask

  task automatic applyStimulus(input logic [N_BTN-1:0] raw, input logic ready, input int cycles);
    btn_raw   = raw;
    cmd_ready = ready;
    repeat (cycles) tick();
  endtask

  initial begin
    int k;
    int n;

    vecs.push_back('{5'b10101, 1'b1, 12, 5'b10101, 8, 5'b10101, 5'b00000});
    vecs.push_back('{5'b00000, 1'b1, 10, 5'b00000, 0, 5'b00000, 5'b00000});
    vecs.push_back('{5'b01000, 1'b0, 12, 5'b00000, 0, 5'b01000, 5'b01000});
    vecs.push_back('{5'b01000, 1'b0, 50, 5'b00000, 0, 5'b01000, 5'b01000});
    vecs.push_back('{5'b01000, 1'b1,  3, 5'b01000, 1, 5'b01000, 5'b00000});
    vecs.push_back('{5'b00000, 1'b1, 10, 5'b00000, 0, 5'b00000, 5'b00000});
    vecs.push_back('{5'b11111, 1'b1, 14, 5'b11111, 8, 5'b11111, 5'b00000});
    vecs.push_back('{5'b00000, 1'b0, 10, 5'b00000, 0, 5'b00000, 5'b00000});
    vecs.push_back('{5'b00110, 1'b0, 10, 5'b00000, 0, 5'b00110, 5'b00110});
    vecs.push_back('{5'b00110, 1'b1,  4, 5'b00110, 1, 5'b00110, 5'b00000});
    vecs.push_back('{5'b00000, 1'b1, 10, 5'b00000, 0, 5'b00000, 5'b00000});

    // Reset state
    applyStimulus('0, 1'b0, 3);
    checkOutput("reset_level", btn_level, '0);
    checkOutput("reset_pending", pending, '0);
    rst_n = 1'b1;
    applyStimulus('0, 1'b0, 2);

    // Single held press: level on cycle 6, one strobe on cycle 8, nothing after
    k = cyc;
    expectPulse(k + DC + 4, 5'b00010);
    applyStimulus(5'b00010, 1'b1, DC + 1);
    checkOutput("level_before_debounce", btn_level, '0);
    applyStimulus(5'b00010, 1'b1, 1);
    checkOutput("level_after_debounce", btn_level, 5'b00010);
    applyStimulus(5'b00010, 1'b1, 1);
    checkOutput("pending_set", pending, 5'b00010);
    applyStimulus(5'b00010, 1'b1, 10);
    checkOutput("pending_issued", pending, '0);
    applyStimulus('0, 1'b1, 10);
    checkOutput("level_released", btn_level, '0);

    // Glitch one cycle shorter than the debounce window
    applyStimulus(5'b00001, 1'b1, DC - 1);
    applyStimulus('0, 1'b1, 4);
    checkOutput("glitch_level", btn_level, '0);
    applyStimulus('0, 1'b1, 8);
    checkOutput("glitch_level_late", btn_level, '0);
    checkOutput("glitch_pending", pending, '0);

    // Table-driven vectors; strobes come out in index order, one per cycle
    foreach (vecs[v]) begin
      k = cyc;
      n = 0;
      for (int b = 0; b < N_BTN; b++) begin
        if (vecs[v].strobes[b]) begin
          expectPulse(k + vecs[v].firstAt + n, N_BTN'(1) << b);
          n++;
        end
      end
      applyStimulus(vecs[v].raw, vecs[v].ready, vecs[v].hold);
      checkOutput($sformatf("vec%0d_level", v), btn_level, vecs[v].expLevel);
      checkOutput($sformatf("vec%0d_pending", v), pending, vecs[v].expPending);
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Held button: press, then repeats after RD and every RP; release stops them
    k = cyc;
    expectPulse(k + DC + 4, 5'b00100);
    for (int m = 0; m < 5; m++) begin
      expectPulse(k + DC + 4 + RD + m * RP, 5'b00100);
    end
    applyStimulus(5'b00100, 1'b1, 60);
    applyStimulus('0, 1'b1, 30);
    checkOutput("repeat_released_level", btn_level, '0);
    checkOutput("repeat_released_pending", pending, '0);
`endif

    // Reset while a press is pending and the button is held
    applyStimulus(5'b00010, 1'b0, 10);
    checkOutput("pre_reset_pending", pending, 5'b00010);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_level", btn_level, '0);
    checkOutput("async_reset_pending", pending, '0);
    checkOutput("async_reset_pulse", btn_pulse, '0);
    applyStimulus(5'b00010, 1'b1, 3);
    checkOutput("in_reset_pending", pending, '0);
    rst_n = 1'b1;
    k = cyc;
    expectPulse(k + DC + 4, 5'b00010);
    applyStimulus(5'b00010, 1'b1, DC + 1);
    checkOutput("post_reset_level_low", btn_level, '0);
    applyStimulus(5'b00010, 1'b1, 10);
    checkOutput("post_reset_level", btn_level, 5'b00010);
    applyStimulus('0, 1'b1, 10);

    while (sbq.size() > 0) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL missed_pulse: got none, expected %b at cycle %0d", sbq[0].pulse, sbq[0].cyc);
      void'(sbq.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
